// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: queued RV32I decode stage with registered control bundle and saturating illegal counter
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`define ALU_ADD  5'b00000
`define ALU_SUB  5'b01000
`define ALU_XOR  5'b00100
`define ALU_OR   5'b00110
`define ALU_AND  5'b00111
`define ALU_SRA  5'b01101
`define ALU_SRL  5'b00101
`define ALU_SLL  5'b00001
`define ALU_LTS  5'b11100
`define ALU_LTU  5'b11110
`define ALU_GES  5'b11101
`define ALU_GEU  5'b11111
`define ALU_EQ   5'b11000
`define ALU_NE   5'b11001
`define ALU_SLTS 5'b00010
`define ALU_SLTU 5'b00011
`endif

module riscv_decode_stage #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              instr_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [1:0]               ex_op_a_sel_o,
  output logic [2:0]               ex_op_b_sel_o,
  output logic [`ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [2:0]               mem_size_o,
  output logic                     gpr_we_a_o,
  output logic                     wb_src_sel_o,
  output logic                     branch_o,
  output logic                     jal_o,
  output logic                     jalr_o,
  output logic                     illegal_instr_o,
  output logic [ILL_CNT_W-1:0]     illegal_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  logic [31:0] h;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [1:0] d_a;
  logic [2:0] d_b, d_size;
  logic [`ALU_OP_WIDTH-1:0] d_alu;
  logic d_mreq, d_mwe, d_we, d_wb, d_br, d_jal, d_jalr, d_ill;

  assign in_ready_o = (count != CW'(DEPTH)) && !flush_i;
  assign push = in_valid_i && in_ready_o;
  assign pop = (count != '0) && (!out_valid_o || out_ready_i) && !flush_i;
  assign h = q_instr[rd_ptr];
  assign f3 = h[14:12];
  assign f7 = h[31:25];

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[wr_ptr] <= instr_i;
      q_pc[wr_ptr] <= pc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The ALU encoding packs {funct7[5], funct3} for register ops and {2'b11, funct3} for compares.
  always_comb begin
    {d_a, d_b, d_size, d_alu, d_mreq, d_mwe, d_we, d_wb, d_br, d_jal, d_jalr} = '0;
    d_ill = 1'b0;
    if (h[1:0] != 2'b11) d_ill = 1'b1;
    else begin
      case (h[6:2])
        5'b00000: begin
          d_ill = (f3 == 3'd3) || (f3 >= 3'd6);
          {d_mreq, d_we, d_wb} = 3'b111;
          d_b = 3'd1;
          d_size = f3;
        end
        5'b01000: begin
          d_ill = f3 > 3'd2;
          {d_mreq, d_mwe} = 2'b11;
          d_b = 3'd3;
          d_size = f3;
        end
        5'b00100: begin
          d_ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
          d_we = 1'b1;
          d_b = 3'd1;
          d_alu = {1'b0, f3 == 3'd5 && f7[5], f3};
        end
        5'b01100: begin
          d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
          d_we = 1'b1;
          d_alu = {1'b0, f7[5], f3};
        end
        5'b01101: begin
          d_we = 1'b1;
          d_a = 2'd2;
          d_b = 3'd2;
        end
        5'b00101: begin
          d_we = 1'b1;
          d_a = 2'd1;
          d_b = 3'd2;
        end
        5'b11000: begin
          d_ill = (f3 == 3'd2) || (f3 == 3'd3);
          d_br = 1'b1;
          d_alu = {2'b11, f3};
        end
        5'b11011: begin
          {d_jal, d_we} = 2'b11;
          d_a = 2'd1;
          d_b = 3'd4;
        end
        5'b11001: begin
          d_ill = f3 != 3'd0;
          {d_jalr, d_we} = 2'b11;
          d_a = 2'd1;
          d_b = 3'd4;
        end
        5'b00011, 5'b11100: d_ill = 1'b0;
        default: d_ill = 1'b1;
      endcase
    end
    if (d_ill) {d_a, d_b, d_size, d_alu, d_mreq, d_mwe, d_we, d_wb, d_br, d_jal, d_jalr} = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      {instr_o, pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o, mem_size_o,
       gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o, illegal_instr_o} <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (pop) begin
      out_valid_o <= 1'b1;
      instr_o <= h;
      pc_o <= q_pc[rd_ptr];
      ex_op_a_sel_o <= d_a;
      ex_op_b_sel_o <= d_b;
      alu_op_o <= d_alu;
      mem_req_o <= d_mreq;
      mem_we_o <= d_mwe;
      mem_size_o <= d_size;
      gpr_we_a_o <= d_we;
      wb_src_sel_o <= d_wb;
      branch_o <= d_br;
      jal_o <= d_jal;
      jalr_o <= d_jalr;
      illegal_instr_o <= d_ill;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) illegal_cnt_o <= '0;
    else if (out_valid_o && out_ready_i && illegal_instr_o && illegal_cnt_o != '1)
      illegal_cnt_o <= illegal_cnt_o + 1'b1;
  end
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: randomized scoreboard bench for the queued RV32I decode stage
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`define ALU_ADD  5'b00000
`define ALU_SUB  5'b01000
`define ALU_XOR  5'b00100
`define ALU_OR   5'b00110
`define ALU_AND  5'b00111
`define ALU_SRA  5'b01101
`define ALU_SRL  5'b00101
`define ALU_SLL  5'b00001
`define ALU_LTS  5'b11100
`define ALU_LTU  5'b11110
`define ALU_GES  5'b11101
`define ALU_GEU  5'b11111
`define ALU_EQ   5'b11000
`define ALU_NE   5'b11001
`define ALU_SLTS 5'b00010
`define ALU_SLTU 5'b00011
`endif

module tb_riscv_decode_stage;
  localparam int DEPTH = 4;
  localparam int ILL_CNT_W = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  a;
    logic [2:0]  b;
    logic [4:0]  alu;
    logic        mreq;
    logic        mwe;
    logic [2:0]  size;
    logic        we;
    logic        wb;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        ill;
  } bundle_t;

  logic clk_i = 1'b0;
  logic rst_i, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] instr_i, pc_i, instr_o, pc_o;
  logic [1:0] ex_op_a_sel_o;
  logic [2:0] ex_op_b_sel_o, mem_size_o;
  logic [`ALU_OP_WIDTH-1:0] alu_op_o;
  logic mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o, illegal_instr_o;
  logic [ILL_CNT_W-1:0] illegal_cnt_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bundle_t sb[$];
  int qc;
  logic ov;
  logic [1:0] mcnt;

  riscv_decode_stage #(.DEPTH(DEPTH), .XLEN(32), .ILL_CNT_W(ILL_CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .instr_o(instr_o), .pc_o(pc_o), .ex_op_a_sel_o(ex_op_a_sel_o),
    .ex_op_b_sel_o(ex_op_b_sel_o), .alu_op_o(alu_op_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_size_o(mem_size_o), .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o),
    .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .illegal_instr_o(illegal_instr_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  function automatic logic [4:0] reg_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? `ALU_SUB : `ALU_ADD;
      3'd1: return `ALU_SLL;
      3'd2: return `ALU_SLTS;
      3'd3: return `ALU_SLTU;
      3'd4: return `ALU_XOR;
      3'd5: return alt ? `ALU_SRA : `ALU_SRL;
      3'd6: return `ALU_OR;
      default: return `ALU_AND;
    endcase
  endfunction

  function automatic logic [4:0] br_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return `ALU_EQ;
      3'd1: return `ALU_NE;
      3'd4: return `ALU_LTS;
      3'd5: return `ALU_GES;
      3'd6: return `ALU_LTU;
      3'd7: return `ALU_GEU;
      default: return `ALU_ADD;
    endcase
  endfunction

  function automatic bundle_t model(input logic [31:0] w, input logic [31:0] pc);
    bundle_t e;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    ok = 1'b1;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.mreq = 1; e.we = 1; e.wb = 1; e.b = 1; e.size = f3; end
      7'h23: begin ok = f3 <= 3'd2; e.mreq = 1; e.mwe = 1; e.b = 3; e.size = f3; end
      7'h13: begin
        ok = (f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        e.we = 1; e.b = 1; e.alu = reg_alu(f3, f3 == 3'd5 && f7 == 7'h20);
      end
      7'h33: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.we = 1; e.alu = reg_alu(f3, f7 == 7'h20);
      end
      7'h37: begin e.we = 1; e.a = 2; e.b = 2; end
      7'h17: begin e.we = 1; e.a = 1; e.b = 2; end
      7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); e.br = 1; e.alu = br_alu(f3); end
      7'h6f: begin e.jal = 1; e.we = 1; e.a = 1; e.b = 4; end
      7'h67: begin ok = f3 == 3'd0; e.jalr = 1; e.we = 1; e.a = 1; e.b = 4; end
      7'h0f, 7'h73: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1;
    end
    e.instr = w;
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [6:0] ops [11] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67, 7'h0f, 7'h73};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) w[6:0] = ops[k];
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 2) != 0)
      w[31:25] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
    return w;
  endfunction

  // Scoreboard: sample just before each rising edge, compare head, then advance the occupancy model.
  always begin : mon
    bundle_t act, e;
    logic hs_in, hs_out, pop_m;
    @(negedge clk_i);
    #4;
    if (rst_i) begin
      sb.delete();
      qc = 0;
      ov = 1'b0;
      mcnt = 2'd0;
    end else begin
      chk("out_valid", out_valid_o, ov);
      chk("in_ready", in_ready_o, (qc != DEPTH) && !flush_i);
      chk("illegal_cnt", illegal_cnt_o, mcnt);
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bundle: got unexpected instr %0h, expected no output", instr_o);
        end else begin
          act = '{instr: instr_o, pc: pc_o, a: ex_op_a_sel_o, b: ex_op_b_sel_o, alu: alu_op_o,
                  mreq: mem_req_o, mwe: mem_we_o, size: mem_size_o, we: gpr_we_a_o, wb: wb_src_sel_o,
                  br: branch_o, jal: jal_o, jalr: jalr_o, ill: illegal_instr_o};
          chk("bundle", act, sb[0]);
        end
      end
      hs_out = ov && out_ready_i;
      hs_in = in_valid_i && (qc != DEPTH) && !flush_i;
      pop_m = (qc > 0) && (!ov || out_ready_i);
      if (hs_out && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.ill && mcnt != 2'b11) mcnt = mcnt + 2'd1;
      end
      if (hs_in) sb.push_back(model(instr_i, pc_i));
      qc = qc + int'(hs_in) - int'(pop_m);
      ov = pop_m || (ov && !out_ready_i);
      if (flush_i) begin
        sb.delete();
        qc = 0;
        ov = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a falling edge; returns at the falling edge after the word is accepted.
  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    int t;
    t = 0;
    in_valid_i = 1'b1;
    instr_i = w;
    pc_i = pc;
    #4;
    while (!in_ready_o && t < 200) begin
      @(negedge clk_i);
      #4;
      t++;
    end
    if (t >= 200) chk("push timeout", 1'b0, 1'b1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] stream [8] = '{32'h0080A283, 32'h0050A623, 32'h00208463, 32'h010000EF,
                                32'h00008067, 32'h12345137, 32'h00001197, 32'h402081B3};
    logic [31:0] bad [5] = '{32'h00000000, 32'h0000707F, 32'h00003003, 32'h02000033, 32'h0000100B};
    int c0;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    flush_i = 1'b0;
    instr_i = '0;
    pc_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst out_valid", out_valid_o, 0);
    chk("rst illegal_cnt", illegal_cnt_o, 0);
    chk("rst instr_o", instr_o, 0);
    chk("rst pc_o", pc_o, 0);
    chk("rst gpr_we", gpr_we_a_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready_o, 1);
    @(negedge clk_i);

    out_ready_i = 1'b1;
    push(32'h00500093, 32'h100);
    #1;
    chk("addi not yet valid", out_valid_o, 0);
    @(negedge clk_i);
    #1;
    chk("addi valid", out_valid_o, 1);
    chk("addi gpr_we", gpr_we_a_o, 1);
    chk("addi b_sel", ex_op_b_sel_o, 1);
    chk("addi alu", alu_op_o, `ALU_ADD);
    chk("addi pc", pc_o, 32'h100);
    chk("addi illegal", illegal_instr_o, 0);
    @(negedge clk_i);
    cycles(2);

    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h00000093 | (i << 20), 32'h200 + 4 * i);
    fork
      push(32'h00600093, 32'h214);
      begin
        #1;
        chk("full in_ready", in_ready_o, 0);
        cycles(2);
        out_ready_i = 1'b1;
      end
    join
    cycles(10);

    out_ready_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) push(stream[i], 32'h400 + 4 * i);
    chk("stream cycles", cyc - c0, 8);
    cycles(5);

    for (int i = 0; i < 3; i++) push(bad[i], 32'h600 + 4 * i);
    cycles(4);
    chk("illegal_cnt 3", illegal_cnt_o, 3);
    for (int i = 3; i < 5; i++) push(bad[i], 32'h600 + 4 * i);
    cycles(4);
    chk("illegal_cnt saturated", illegal_cnt_o, 3);

    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h00000113 | (i << 20), 32'h800 + 4 * i);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    instr_i = 32'h00C00313;
    pc_i = 32'h900;
    @(negedge clk_i);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("flush out_valid", out_valid_o, 0);
    chk("flush in_ready", in_ready_o, 1);
    chk("flush illegal_cnt", illegal_cnt_o, 3);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    cycles(6);
    #1;
    chk("flush nothing emerges", out_valid_o, 0);
    @(negedge clk_i);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("async rst out_valid", out_valid_o, 0);
        chk("async rst illegal_cnt", illegal_cnt_o, 0);
        chk("async rst instr_o", instr_o, 0);
        chk("async rst mem_req", mem_req_o, 0);
        chk("async rst alu", alu_op_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
      end else begin
        in_valid_i = $urandom_range(0, 3) != 0;
        instr_i = rnd_word();
        pc_i = $urandom;
        out_ready_i = $urandom_range(0, 2) != 0;
        flush_i = $urandom_range(0, 39) == 0;
        @(negedge clk_i);
      end
    end

    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    cycles(12);
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
